apb_completer_regs: RTL and testbench

//  - APB3 completer (slave) register block: answers transfers from the APB requester and drives pready, prdata and pslverr.
//  - Holds a small control/status register map with one RO and one WO location.
//  - Inserts 0..15 programmable wait states.
//  - Sits between the APB interconnect and a peripheral core.

---
 rtl/apb_completer_regs_pkg.sv | 9 +
 rtl/apb_completer_regs_if.sv | 16 +
 rtl/apb_completer_regs_addr_decode.sv | 22 ++
 rtl/apb_completer_regs.sv | 110 +++++++++++
 tb/tb_apb_completer_regs.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_completer_regs_pkg.sv
// apb_pkg: state encoding and register offsets shared by the APB completer files
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_cmp_state_e;
  localparam int CTRL_OFS = 'h00;
  localparam int STATUS_OFS = 'h04;
  localparam int CMD_OFS = 'h08;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
endpackage

// File: rtl/apb_completer_regs_if.sv
// apb_completer_regs_if: APB3 bus signals with requester (master) and completer (slave) views
interface apb_completer_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_completer_regs_addr_decode.sv
// apb_addr_decode: maps a byte address and direction to a register index and an error flag
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_pwrite,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_err
);
  logic w_range_err;
  logic w_ro_err;
  logic w_wo_err;
  assign o_idx = i_paddr[IDX_W+1:2];
  assign w_range_err = (i_paddr >= ADDR_W'(NUM_REGS * 4)) || (i_paddr[1:0] != 2'b00);
  assign w_ro_err = i_pwrite && (o_idx == IDX_W'(STATUS_OFS / 4));
  assign w_wo_err = !i_pwrite && (o_idx == IDX_W'(CMD_OFS / 4));
  assign o_err = w_range_err || w_ro_err || w_wo_err;
endmodule

// File: rtl/apb_completer_regs.sv
// apb_completer_regs: APB3 completer register block with optional wait states.
// Define APB_WAIT_STATES_EN to take 0..15 wait states from CTRL[3:0]; otherwise zero-wait.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_completer_regs_if.slave bus,
  input  logic [DATA_W-1:0]   status_i,
  output logic [DATA_W-1:0]   ctrl_o,
  output logic                cmd_o,
  output logic [DATA_W-1:0]   cmd_data_o
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(CTRL_OFS / 4);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(STATUS_OFS / 4);
  localparam logic [IDX_W-1:0] CMD_IDX = IDX_W'(CMD_OFS / 4);
  apb_cmp_state_e r_state, w_state_nx;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_prdata, r_cmd_data, w_rdata;
  logic [IDX_W-1:0] r_idx, w_dec_idx, w_idx;
  logic [CNT_W-1:0] w_n;
  logic r_err, r_write, r_pready, r_pslverr, r_cmd;
  logic w_dec_err, w_err, w_write, w_setup, w_respond, w_latch, w_commit;
`ifdef APB_WAIT_STATES_EN
  logic [CNT_W-1:0] r_cnt;
  assign w_n = ctrl_o[CNT_W-1:0];
`else
  assign w_n = '0;
`endif
  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec (
    .i_paddr  (bus.paddr),
    .i_pwrite (bus.pwrite),
    .o_idx    (w_dec_idx),
    .o_err    (w_dec_err)
  );
  assign w_setup = bus.psel && !bus.penable;
  // Zero-wait responses come straight from the decoder; later ones use the setup-time capture
  assign w_idx = (r_state == IDLE) ? w_dec_idx : r_idx;
  assign w_err = (r_state == IDLE) ? w_dec_err : r_err;
  assign w_write = (r_state == IDLE) ? bus.pwrite : r_write;
  assign w_rdata = (w_idx == STATUS_IDX) ? status_i : r_regs[w_idx];
  always_comb begin
    w_state_nx = r_state;
    w_respond = 1'b0;
    w_latch = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: if (w_setup) begin
        w_latch = 1'b1;
        w_respond = (w_n == '0);
        w_state_nx = w_respond ? DONE : WAIT;
      end
`ifdef APB_WAIT_STATES_EN
      WAIT: begin
        w_respond = bus.psel && (r_cnt == CNT_W'(1));
        w_state_nx = !bus.psel ? IDLE : (w_respond ? DONE : WAIT);
      end
`endif
      DONE: begin
        w_commit = bus.psel && bus.penable && r_write && !r_err;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge pclk) r_state <= !presetn ? IDLE : w_state_nx;
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_idx <= '0;
      r_err <= 1'b0;
      r_write <= 1'b0;
      r_pready <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata <= '0;
      r_cmd <= 1'b0;
      r_cmd_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_latch) begin
        r_idx <= w_dec_idx;
        r_err <= w_dec_err;
        r_write <= bus.pwrite;
      end
      r_pready <= w_respond;
      r_pslverr <= w_respond && w_err;
      r_prdata <= (w_respond && !w_err && !w_write) ? w_rdata : '0;
      r_cmd <= w_commit && (r_idx == CMD_IDX);
      if (w_commit && (r_idx == CMD_IDX)) r_cmd_data <= bus.pwdata;
      if (w_commit && (r_idx != CMD_IDX)) r_regs[r_idx] <= bus.pwdata;
    end
  end
`ifdef APB_WAIT_STATES_EN
  always_ff @(posedge pclk) begin
    if (!presetn) r_cnt <= '0;
    else if (w_latch) r_cnt <= w_n;
    else if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
  end
`endif
  assign bus.pready = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata = r_prdata;
  assign ctrl_o = r_regs[CTRL_IDX];
  assign cmd_o = r_cmd;
  assign cmd_data_o = r_cmd_data;
endmodule

// File: tb/tb_apb_completer_regs.sv
// tb_apb_completer_regs: directed self-checking bench for apb_completer_regs (both wait-state builds)
module tb_apb_completer_regs;
  logic clk = 1'b0;
  logic rstn;
  logic [31:0] status;
  logic [31:0] ctrl;
  logic cmd;
  logic [31:0] cmd_data;
  int n_vec = 0;
  int n_bad = 0;
  apb_completer_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_completer_regs #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8)) dut (
    .pclk       (clk),
    .presetn    (rstn),
    .bus        (bus),
    .status_i   (status),
    .ctrl_o     (ctrl),
    .cmd_o      (cmd),
    .cmd_data_o (cmd_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int waits);
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = wr;
    bus.paddr = addr;
    bus.pwdata = wdata;
    tick();
    bus.penable = 1'b1;
    waits = 0;
    while (bus.pready !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    rdata = bus.prdata;
    err = bus.pslverr;
    tick();
    bus.psel = 1'b0;
    bus.penable = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h00, 32'h30, d, e, w);
    xfer(1'b1, 32'h0C, 32'h5A, d, e, w);
    n_vec++; if (ctrl !== 32'h30) begin n_bad++; $display("FAIL rst_preload_ctrl: got %h want %h", ctrl, 32'h30); end
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h0C; bus.pwdata = 32'hA5A5A5A5;
    tick();
    bus.penable = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    n_vec++; if (bus.pready !== 1'b0) begin n_bad++; $display("FAIL rst_pready: got %b want 0", bus.pready); end
    n_vec++; if (bus.prdata !== 32'h0) begin n_bad++; $display("FAIL rst_prdata: got %h want 0", bus.prdata); end
    n_vec++; if (bus.pslverr !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr: got %b want 0", bus.pslverr); end
    n_vec++; if (ctrl !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
    n_vec++; if (cmd !== 1'b0) begin n_bad++; $display("FAIL rst_cmd: got %b want 0", cmd); end
    rstn = 1'b1;
    tick();
    n_vec++; if (bus.pready !== 1'b0) begin n_bad++; $display("FAIL penable_no_setup_a: got %b want 0", bus.pready); end
    tick();
    n_vec++; if (bus.pready !== 1'b0) begin n_bad++; $display("FAIL penable_no_setup_b: got %b want 0", bus.pready); end
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();
    xfer(1'b0, 32'h0C, 32'h0, d, e, w);
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_scratch: got %h want 0", d); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL rst_scratch_err: got %b want 0", e); end
  endtask
  task automatic test_zero_wait();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h00, 32'h0, d, e, w);
    xfer(1'b1, 32'h0C, 32'hDEADBEEF, d, e, w);
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL zw_wr_waits: got %0d want 0", w); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL zw_wr_err: got %b want 0", e); end
    n_vec++; if (bus.pready !== 1'b0) begin n_bad++; $display("FAIL zw_pready_one_cycle: got %b want 0", bus.pready); end
    xfer(1'b0, 32'h0C, 32'h0, d, e, w);
    n_vec++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL zw_rd_data: got %h want %h", d, 32'hDEADBEEF); end
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL zw_rd_waits: got %0d want 0", w); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    logic e1, e2;
    int w1, w2;
    xfer(1'b1, 32'h10, 32'h11111111, d1, e1, w1);
    xfer(1'b1, 32'h1C, 32'h1C1C1C1C, d1, e1, w1);
    xfer(1'b0, 32'h10, 32'h0, d1, e1, w1);
    xfer(1'b0, 32'h1C, 32'h0, d2, e2, w2);
    n_vec++; if (d1 !== 32'h11111111) begin n_bad++; $display("FAIL b2b_rd_10: got %h want %h", d1, 32'h11111111); end
    n_vec++; if (d2 !== 32'h1C1C1C1C) begin n_bad++; $display("FAIL b2b_rd_1c: got %h want %h", d2, 32'h1C1C1C1C); end
    n_vec++; if ({e1, e2} !== 2'b00) begin n_bad++; $display("FAIL b2b_err: got %b want 00", {e1, e2}); end
    n_vec++; if (w2 !== 0) begin n_bad++; $display("FAIL b2b_waits: got %0d want 0", w2); end
  endtask
  task automatic test_errors();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h04, 32'hFFFFFFFF, d, e, w);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_wr_status: got %b want 1", e); end
    xfer(1'b0, 32'h04, 32'h0, d, e, w);
    n_vec++; if (d !== 32'h1234 || e !== 1'b0) begin n_bad++; $display("FAIL err_status_kept: got %h/%b want 00001234/0", d, e); end
    xfer(1'b0, 32'h08, 32'h0, d, e, w);
    n_vec++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL err_rd_cmd: got %h/%b want 00000000/1", d, e); end
    xfer(1'b0, 32'h20, 32'h0, d, e, w);
    n_vec++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL err_rd_range: got %h/%b want 00000000/1", d, e); end
    xfer(1'b1, 32'h20, 32'hFFFFFFFF, d, e, w);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_wr_range: got %b want 1", e); end
    xfer(1'b1, 32'h02, 32'hFFFFFFFF, d, e, w);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_wr_misalign: got %b want 1", e); end
    xfer(1'b0, 32'h0E, 32'h0, d, e, w);
    n_vec++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL err_rd_misalign: got %h/%b want 00000000/1", d, e); end
    n_vec++; if (ctrl !== 32'h0) begin n_bad++; $display("FAIL err_ctrl_untouched: got %h want 0", ctrl); end
    n_vec++; if (cmd !== 1'b0) begin n_bad++; $display("FAIL err_no_cmd: got %b want 0", cmd); end
  endtask
  task automatic test_cmd();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h08, 32'h77, d, e, w);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL cmd_err: got %b want 0", e); end
    n_vec++; if (cmd !== 1'b1) begin n_bad++; $display("FAIL cmd_pulse: got %b want 1", cmd); end
    n_vec++; if (cmd_data !== 32'h77) begin n_bad++; $display("FAIL cmd_data: got %h want %h", cmd_data, 32'h77); end
    tick();
    n_vec++; if (cmd !== 1'b0) begin n_bad++; $display("FAIL cmd_pulse_end: got %b want 0", cmd); end
  endtask
  task automatic test_done_abort();
    logic [31:0] d;
    logic e;
    int w;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h14; bus.pwdata = 32'h99999999;
    tick();
    bus.psel = 1'b0;
    tick();
    n_vec++; if (bus.pready !== 1'b0) begin n_bad++; $display("FAIL done_abort_pready: got %b want 0", bus.pready); end
    xfer(1'b0, 32'h14, 32'h0, d, e, w);
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL done_abort_nowrite: got %h want 0", d); end
  endtask
`ifdef APB_WAIT_STATES_EN
  task automatic test_wait_states();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h00, 32'h5, d, e, w);
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL ws_ctrl5_own_waits: got %0d want 0", w); end
    xfer(1'b0, 32'h04, 32'h0, d, e, w);
    n_vec++; if (w !== 5) begin n_bad++; $display("FAIL ws5_waits: got %0d want 5", w); end
    n_vec++; if (d !== 32'h1234) begin n_bad++; $display("FAIL ws5_data: got %h want %h", d, 32'h1234); end
    xfer(1'b1, 32'h00, 32'hF, d, e, w);
    n_vec++; if (w !== 5) begin n_bad++; $display("FAIL ws_ctrlF_own_waits: got %0d want 5", w); end
    status = 32'hCAFE0001;
    xfer(1'b0, 32'h04, 32'h0, d, e, w);
    n_vec++; if (w !== 15) begin n_bad++; $display("FAIL ws15_waits: got %0d want 15", w); end
    n_vec++; if (d !== 32'hCAFE0001 || e !== 1'b0) begin n_bad++; $display("FAIL ws15_data: got %h/%b want cafe0001/0", d, e); end
    status = 32'h1234;
    xfer(1'b1, 32'h00, 32'h0, d, e, w);
    n_vec++; if (w !== 15) begin n_bad++; $display("FAIL ws_ctrl0_own_waits: got %0d want 15", w); end
  endtask
  task automatic abort_in_wait(input logic [31:0] addr, input logic [31:0] wdata);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = addr; bus.pwdata = wdata;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();
  endtask
  task automatic test_wait_abort();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h00, 32'h3, d, e, w);
    abort_in_wait(32'h08, 32'hBAD);
    n_vec++; if (bus.pready !== 1'b0 || cmd !== 1'b0) begin n_bad++; $display("FAIL abort_cmd: got pready %b cmd %b want 0 0", bus.pready, cmd); end
    tick();
    n_vec++; if (cmd !== 1'b0 || cmd_data !== 32'h77) begin n_bad++; $display("FAIL abort_cmd_late: got %b/%h want 0/00000077", cmd, cmd_data); end
    abort_in_wait(32'h10, 32'h55555555);
    xfer(1'b0, 32'h10, 32'h0, d, e, w);
    n_vec++; if (d !== 32'h11111111 || e !== 1'b0) begin n_bad++; $display("FAIL abort_nowrite: got %h/%b want 11111111/0", d, e); end
    n_vec++; if (w !== 3) begin n_bad++; $display("FAIL abort_next_waits: got %0d want 3", w); end
    xfer(1'b1, 32'h00, 32'h0, d, e, w);
  endtask
`else
  task automatic test_wait_states();
    logic [31:0] d;
    logic e;
    int w;
    xfer(1'b1, 32'h00, 32'h5, d, e, w);
    xfer(1'b0, 32'h00, 32'h0, d, e, w);
    n_vec++; if (d !== 32'h5) begin n_bad++; $display("FAIL nows_ctrl_store: got %h want 5", d); end
    xfer(1'b0, 32'h04, 32'h0, d, e, w);
    n_vec++; if (w !== 0) begin n_bad++; $display("FAIL nows_waits: got %0d want 0", w); end
    n_vec++; if (d !== 32'h1234) begin n_bad++; $display("FAIL nows_data: got %h want %h", d, 32'h1234); end
    xfer(1'b1, 32'h00, 32'h0, d, e, w);
  endtask
`endif
  initial begin
    rstn = 1'b0;
    status = 32'h1234;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    bus.paddr = '0;
    bus.pwdata = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_zero_wait();
    test_back_to_back();
    test_errors();
    test_cmd();
    test_done_abort();
    test_wait_states();
`ifdef APB_WAIT_STATES_EN
    test_wait_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
